controlleur_mc: RTL and testbench
=================================

Name: controlleur_mc

Overview:
Parametrised multi-cycle control FSM, next generation of the CPU controller. Sequences FETCH/DECODE/EXEC/MEM/WB for the core datapath and drives the PC, instruction register, register-file and data-memory strobes. New capabilities over the previous controller:
- memory ready/handshake with a wait-state timeout;
- pipeline-freeze stall input;
- HALT and ERROR terminal states;
- configurable opcode width.

Parameters:
OPCODE_W, 6, opcode input width (>=6); any nonzero bit above bit 5 makes the opcode illegal.
TIMEOUT_W, 4, width of the memory wait counter.
MEM_TIMEOUT, 15, wait cycles tolerated before ERROR; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  OPCODE_W  opcode field of the instruction register
zero  in  1  ALU zero flag, sampled in EXEC
mem_ready  in  1  memory completes the current request this cycle
stall  in  1  freeze FSM and suppress strobes
mem_req  out  1  memory request (FETCH, MEM)
read_word  out  1  word read request (FETCH; MEM for LW)
enable_write  out  1  data-memory write strobe (SW)
enable_I  out  1  instruction register load
enable_reg  out  1  register-file write
sel_inc  out  1  PC source = PC+4
enable_PC  out  1  PC update
load_new_PC  out  1  PC source = jump/branch target
link  out  1  write return address to r31
instr_done  out  1  one-cycle pulse per retired instruction
halted  out  1  FSM in HALT
error  out  1  FSM in ERROR (sticky)

Behaviour:
Opcode encodings (low 6 bits): R=0x00, ADDI=0x08, LW=0x23, SW=0x2B, J=0x02, JAL=0x03, BEQ=0x04, HALT=0x3F. All other values are illegal.

Reset:
- The cycle after reset is sampled high: state=FETCH, wait counter=0, error=0, halted=0.
- While reset is high, all outputs are forced to 0.
- Reset mid-instruction aborts it; no strobe fires in the reset cycle.

Output decoding:
- Outputs are combinational from state, latched op_q, mem_ready, zero and stall. Mealy terms are listed per state.
- Any output not listed for a state is 0.

FETCH:
- mem_req=1, read_word=1.
- If mem_ready: enable_I=1, sel_inc=1, enable_PC=1, go to DECODE.
- Otherwise stay.

DECODE:
- op_q<=opcode.
- J: load_new_PC=1, enable_PC=1, instr_done=1, go to FETCH.
- JAL: same as J, plus link=1 and enable_reg=1.
- HALT: go to HALT.
- Illegal: go to ERROR.
- Otherwise: go to EXEC.

EXEC:
- BEQ: if zero, load_new_PC=1 and enable_PC=1. Then instr_done=1, go to FETCH.
- LW/SW: go to MEM.
- R/ADDI: go to WB.

MEM:
- mem_req=1; read_word=1 for LW.
- SW: enable_write=1 only in the cycle mem_ready=1.
- On mem_ready: SW goes to FETCH with instr_done=1; LW goes to WB.

WB: enable_reg=1, instr_done=1, go to FETCH.

HALT: halted=1; held until reset.

ERROR: error=1; held until reset.

Wait counter:
- Cleared on entry to FETCH/MEM.
- Increments each non-stalled cycle with mem_req=1 and mem_ready=0, saturating at all ones.
- If MEM_TIMEOUT≠0, counter==MEM_TIMEOUT and mem_ready=0, go to ERROR next cycle.
- mem_ready=1 in that same cycle wins: normal completion.

Stall (any state except HALT/ERROR):
- State, op_q and counter are held.
- enable_I, enable_reg, enable_write, enable_PC, load_new_PC, link, sel_inc and instr_done are forced 0.
- mem_req and read_word stay asserted; mem_ready is ignored.
- stall and reset together: reset wins.

Optional Feature:
CONTROLLEUR_PERF_EN:
- Defined: adds output instr_count (32 bits). It resets to 0 and increments on each instr_done, wrapping 0xFFFFFFFF→0. It also adds output stall_cycles (32 bits), which counts cycles with stall=1 outside HALT/ERROR and saturates at all ones.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- Reset, then R-type (0x00) with mem_ready=1 in fetch → FETCH, DECODE, EXEC, WB. enable_I+enable_PC+sel_inc in cycle 1; enable_reg+instr_done in cycle 4; 4 cycles per instruction.
- LW (0x23) with mem_ready delayed 3 cycles in MEM → read_word held 4 cycles; then WB enable_reg=1. SW (0x2B) → enable_write=1 exactly in the mem_ready cycle; no WB.
- JAL (0x03) → in DECODE: load_new_PC=1, enable_PC=1, link=1, enable_reg=1, instr_done=1. BEQ with zero=0 → no enable_PC in EXEC; with zero=1 → load_new_PC=1.
- FETCH with mem_ready=0 for 16 cycles (MEM_TIMEOUT=15) → error=1 from the next cycle and sticky. Repeat with mem_ready=1 on the 16th cycle → normal DECODE.
- stall=1 for 3 cycles during WB → enable_reg=0 for those cycles, then enable_reg=1 once after release. Opcode 0x3F → halted=1 and no further strobes. Opcode 0x11 → error=1. Reset high during MEM → FETCH next cycle, all strobes 0.
- With CONTROLLEUR_PERF_EN: 5 instructions plus 7 stall cycles → instr_count=5, stall_cycles=7. Reset → both 0.

Source files
------------

// File: rtl/controlleur_mc.sv
// Multi-cycle core controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshake, wait-state timeout, stall freeze, HALT and ERROR.
// Inputs : clk, reset (sync, active-high), opcode, zero, mem_ready, stall
// Outputs: mem_req, read_word, enable_write, enable_I, enable_reg,
//          sel_inc, enable_PC, load_new_PC, link, instr_done, halted, error
// Option : CONTROLLEUR_PERF_EN adds instr_count and stall_cycles (32 bit).
module controlleur_mc #(
  parameter int OPCODE_W    = 6,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                stall,
  output logic                mem_req,
  output logic                read_word,
  output logic                enable_write,
  output logic                enable_I,
  output logic                enable_reg,
  output logic                sel_inc,
  output logic                enable_PC,
  output logic                load_new_PC,
  output logic                link,
  output logic                instr_done,
  output logic                halted,
  output logic                error
`ifdef CONTROLLEUR_PERF_EN
  ,
  output logic [31:0]         instr_count,
  output logic [31:0]         stall_cycles
`endif
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERROR
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [5:0]           op_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 hi_clear;
  logic                 legal;
  logic                 tmo;
  logic [5:0]           op_lo;

  assign op_lo = opcode[5:0];

  // Opcode bits above the base 6-bit field must be zero.
  if (OPCODE_W > 6) begin : g_hi
    assign hi_clear = ~|opcode[OPCODE_W-1:6];
  end else begin : g_nohi
    assign hi_clear = 1'b1;
  end

  always_comb begin
    legal = 1'b0;
    case (op_lo)
      OP_R, OP_ADDI, OP_LW, OP_SW,
      OP_J, OP_JAL, OP_BEQ, OP_HALT: legal = hi_clear;
      default:                       legal = 1'b0;
    endcase
  end

  assign tmo = (MEM_TIMEOUT != 0) &&
               (cnt_q == TIMEOUT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    read_word    = 1'b0;
    enable_write = 1'b0;
    enable_I     = 1'b0;
    enable_reg   = 1'b0;
    sel_inc      = 1'b0;
    enable_PC    = 1'b0;
    load_new_PC  = 1'b0;
    link         = 1'b0;
    instr_done   = 1'b0;
    halted       = 1'b0;
    error        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        read_word = 1'b1;
        if (!stall) begin
          if (mem_ready) begin
            enable_I  = 1'b1;
            sel_inc   = 1'b1;
            enable_PC = 1'b1;
            state_d   = S_DECODE;
          end else if (tmo) begin
            state_d = S_ERROR;
          end
        end
      end
      S_DECODE: begin
        if (!stall) begin
          if (!legal) begin
            state_d = S_ERROR;
          end else begin
            case (op_lo)
              OP_J, OP_JAL: begin
                load_new_PC = 1'b1;
                enable_PC   = 1'b1;
                instr_done  = 1'b1;
                link        = (op_lo == OP_JAL);
                enable_reg  = (op_lo == OP_JAL);
                state_d     = S_FETCH;
              end
              OP_HALT: state_d = S_HALT;
              default: state_d = S_EXEC;
            endcase
          end
        end
      end
      S_EXEC: begin
        if (!stall) begin
          case (op_q)
            OP_BEQ: begin
              load_new_PC = zero;
              enable_PC   = zero;
              instr_done  = 1'b1;
              state_d     = S_FETCH;
            end
            OP_LW, OP_SW: state_d = S_MEM;
            default:      state_d = S_WB;
          endcase
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        read_word = (op_q == OP_LW);
        if (!stall) begin
          if (mem_ready) begin
            if (op_q == OP_SW) begin
              enable_write = 1'b1;
              instr_done   = 1'b1;
              state_d      = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (tmo) begin
            state_d = S_ERROR;
          end
        end
      end
      S_WB: begin
        if (!stall) begin
          enable_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: error  = 1'b1;
      default: state_d = S_ERROR;
    endcase
    // Reset masks every output, including the terminal flags.
    if (reset) begin
      mem_req      = 1'b0;
      read_word    = 1'b0;
      enable_write = 1'b0;
      enable_I     = 1'b0;
      enable_reg   = 1'b0;
      sel_inc      = 1'b0;
      enable_PC    = 1'b0;
      load_new_PC  = 1'b0;
      link         = 1'b0;
      instr_done   = 1'b0;
      halted       = 1'b0;
      error        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && !stall)
        op_q <= op_lo;
      if (!stall) begin
        if (state_d != state_q &&
            (state_d == S_FETCH || state_d == S_MEM))
          cnt_q <= '0;
        else if (mem_req && !mem_ready && cnt_q != '1)
          cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef CONTROLLEUR_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (instr_done)
        instr_count <= instr_count + 32'd1;
      if (stall && state_q != S_HALT &&
          state_q != S_ERROR && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_controlleur_mc.sv
// Scoreboard bench for controlleur_mc: instruction-level trace model,
// random opcodes/latencies/stalls, monitor compares every cycle.
module tb_controlleur_mc;

  localparam int OPCODE_W    = 6;
  localparam int TIMEOUT_W   = 4;
  localparam int MEM_TIMEOUT = 15;

  typedef struct packed {
    logic mr, rd, ew, ei, er, si, ep, ln, lk, id, h, e;
  } exp_t;

  logic clk = 0;
  logic reset = 1;
  logic [OPCODE_W-1:0] opcode = '0;
  logic zero = 0;
  logic mem_ready = 0;
  logic stall = 0;
  logic mem_req, read_word, enable_write, enable_I, enable_reg;
  logic sel_inc, enable_PC, load_new_PC, link, instr_done;
  logic halted, error;
`ifdef CONTROLLEUR_PERF_EN
  logic [31:0] instr_count, stall_cycles;
`endif

  controlleur_mc #(
    .OPCODE_W(OPCODE_W),
    .TIMEOUT_W(TIMEOUT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .stall(stall),
    .mem_req(mem_req), .read_word(read_word),
    .enable_write(enable_write), .enable_I(enable_I),
    .enable_reg(enable_reg), .sel_inc(sel_inc),
    .enable_PC(enable_PC), .load_new_PC(load_new_PC),
    .link(link), .instr_done(instr_done),
    .halted(halted), .error(error)
`ifdef CONTROLLEUR_PERF_EN
    , .instr_count(instr_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string nm_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    retired = 0;
  int    stalls  = 0;
  bit    stall_en = 0;

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = {mem_req, read_word, enable_write, enable_I, enable_reg,
           sel_inc, enable_PC, load_new_PC, link, instr_done,
           halted, error};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s t=%0t got %b required %b", n, $time, a, e);
      end
    end
  end

  function automatic exp_t mk(bit mr, bit rd, bit ew, bit ei,
                              bit er, bit si, bit ep, bit ln,
                              bit lk, bit id, bit h, bit e);
    return '{mr, rd, ew, ei, er, si, ep, ln, lk, id, h, e};
  endfunction

  function automatic logic [OPCODE_W-1:0] rop();
    return OPCODE_W'($urandom);
  endfunction

  function automatic bit is_legal(logic [OPCODE_W-1:0] op);
    int v;
    v = int'(op);
    return v inside {'h00, 'h08, 'h23, 'h2B, 'h02, 'h03, 'h04, 'h3F};
  endfunction

  task automatic push(exp_t e, string n);
    exp_q.push_back(e);
    nm_q.push_back(n);
  endtask

  // One architectural cycle, optionally preceded by frozen cycles.
  task automatic step(bit rdy, logic [OPCODE_W-1:0] op, bit z,
                      exp_t e, string n);
    int ns;
    ns = 0;
    if (stall_en && $urandom_range(0, 3) == 0)
      ns = $urandom_range(1, 3);
    for (int k = 0; k < ns; k++) begin
      @(posedge clk); #1;
      reset = 0; stall = 1;
      mem_ready = 1'($urandom); zero = 1'($urandom); opcode = rop();
      push(mk(e.mr, e.rd, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {n, "_stall"});
      stalls++;
    end
    @(posedge clk); #1;
    reset = 0; stall = 0;
    mem_ready = rdy; zero = z; opcode = op;
    push(e, n);
  endtask

  task automatic rst_step();
    @(posedge clk); #1;
    reset = 1; stall = 1'($urandom);
    mem_ready = 1'($urandom); opcode = rop();
    push('0, "reset");
    retired = 0;
    stalls = 0;
  endtask

  // Terminal state: outputs frozen regardless of inputs, then reset.
  task automatic term(bit is_err, int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      reset = 0; stall = 1'($urandom);
      mem_ready = 1'($urandom); zero = 1'($urandom); opcode = rop();
      push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, !is_err, is_err),
           is_err ? "error_hold" : "halt_hold");
    end
    rst_step();
  endtask

  task automatic do_instr(logic [OPCODE_W-1:0] op, bit z,
                          int lf, int lm, int abort_mem);
    int  v;
    bit  is_lw;
    v = int'(op);
    is_lw = (v == 'h23);
    for (int i = 0; i < lf; i++) begin
      step(0, rop(), 1'($urandom),
           mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_wait");
      if (MEM_TIMEOUT != 0 && i == MEM_TIMEOUT) begin
        term(1, 3);
        return;
      end
    end
    step(1, rop(), 1'($urandom),
         mk(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0), "fetch_done");
    if (!is_legal(op)) begin
      step(1'($urandom), op, 1'($urandom), '0, "decode_illegal");
      term(1, 3);
      return;
    end
    if (v == 'h02 || v == 'h03) begin
      step(1'($urandom), op, 1'($urandom),
           mk(0, 0, 0, 0, v == 'h03, 0, 1, 1, v == 'h03, 1, 0, 0),
           v == 'h03 ? "jal" : "j");
      retired++;
      return;
    end
    if (v == 'h3F) begin
      step(1'($urandom), op, 1'($urandom), '0, "decode_halt");
      term(0, 3);
      return;
    end
    step(1'($urandom), op, 1'($urandom), '0, "decode");
    if (v == 'h04) begin
      step(1'($urandom), rop(), z,
           mk(0, 0, 0, 0, 0, 0, z, z, 0, 1, 0, 0), "beq_exec");
      retired++;
      return;
    end
    step(1'($urandom), rop(), 1'($urandom), '0, "exec");
    if (v == 'h23 || v == 'h2B) begin
      for (int i = 0; i < lm; i++) begin
        if (i == abort_mem) begin
          rst_step();
          return;
        end
        step(0, rop(), 1'($urandom),
             mk(1, is_lw, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mem_wait");
        if (MEM_TIMEOUT != 0 && i == MEM_TIMEOUT) begin
          term(1, 3);
          return;
        end
      end
      step(1, rop(), 1'($urandom),
           mk(1, is_lw, !is_lw, 0, 0, 0, 0, 0, 0, !is_lw, 0, 0),
           is_lw ? "lw_mem_done" : "sw_mem_done");
      if (!is_lw) begin
        retired++;
        return;
      end
    end
    step(1'($urandom), rop(), 1'($urandom),
         mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0), "wb");
    retired++;
  endtask

  function automatic logic [OPCODE_W-1:0] pick_op();
    int tbl[8] = '{'h00, 'h08, 'h23, 'h2B, 'h02, 'h03, 'h04, 'h3F};
    int idx;
    logic [OPCODE_W-1:0] o;
    idx = $urandom_range(0, 8);
    if (idx < 8) return OPCODE_W'(tbl[idx]);
    o = rop();
    while (is_legal(o)) o = rop();
    return o;
  endfunction

  initial begin
    rst_step();
    rst_step();
    do_instr('h00, 0, 0, 0, -1);
    do_instr('h23, 0, 0, 3, -1);
    do_instr('h2B, 0, 1, 2, -1);
    do_instr('h03, 0, 0, 0, -1);
    do_instr('h02, 0, 2, 0, -1);
    do_instr('h04, 0, 0, 0, -1);
    do_instr('h04, 1, 0, 0, -1);
    do_instr('h08, 0, 0, 0, -1);
    do_instr('h00, 0, 16, 0, -1);
    do_instr('h00, 0, 15, 0, -1);
    do_instr('h23, 0, 0, 15, -1);
    do_instr('h2B, 0, 0, 16, -1);
    do_instr('h3F, 0, 0, 0, -1);
    do_instr('h11, 0, 0, 0, -1);
    do_instr('h23, 0, 0, 3, 1);
    do_instr('h00, 0, 0, 0, -1);
    stall_en = 1;
    for (int n = 0; n < 120; n++)
      do_instr(pick_op(), 1'($urandom), $urandom_range(0, 4),
               $urandom_range(0, 4), -1);
    do_instr('h00, 0, 1, 0, -1);
    @(posedge clk); #1;
    stall = 0; mem_ready = 0; reset = 0;
`ifdef CONTROLLEUR_PERF_EN
    n_tests++;
    if (instr_count !== 32'(retired)) begin
      n_fail++;
      $display("FAIL instr_count got %0d required %0d",
               instr_count, retired);
    end
    n_tests++;
    if (stall_cycles !== 32'(stalls)) begin
      n_fail++;
      $display("FAIL stall_cycles got %0d required %0d",
               stall_cycles, stalls);
    end
`endif
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
